// File: rtl/counter_sweep_ctrl_pkg.sv
// Shared types and constants for the counter triangle-sweep sequencer.
package counter_sweep_pkg;

  localparam int unsigned SWEEP_WIDTH  = 8;
  localparam int unsigned PERIOD_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    UP   = 3'd2,
    DOWN = 3'd3,
    DONE = 3'd4
  } sweep_state_t;

endpackage

// File: rtl/counter_sweep_ctrl_if.sv
// Handshake and counter-control bundle between the sweep sequencer, its requester and the counter.
interface counter_sweep_ctrl_if #(
  parameter int unsigned WIDTH = counter_sweep_pkg::SWEEP_WIDTH
);
  import counter_sweep_pkg::*;

  logic                    start;
  logic                    abort;
  logic [WIDTH-1:0]        lo;
  logic [WIDTH-1:0]        hi;
  logic [PERIOD_WIDTH-1:0] periods;
  logic [WIDTH-1:0]        ctr_count;
  logic                    ctr_load;
  logic                    ctr_up_down;
  logic [WIDTH-1:0]        ctr_load_data;
  logic                    busy;
  logic                    done;
  logic                    cfg_err;
  logic [PERIOD_WIDTH-1:0] period_cnt;

  modport master (
    output start, abort, lo, hi, periods, ctr_count,
    input  ctr_load, ctr_up_down, ctr_load_data, busy, done, cfg_err, period_cnt
  );

  modport slave (
    input  start, abort, lo, hi, periods, ctr_count,
    output ctr_load, ctr_up_down, ctr_load_data, busy, done, cfg_err, period_cnt
  );

endinterface

// File: rtl/counter.sv
// Free-running 8-bit up/down counter with synchronous parallel load; the sequencer's plant.
module counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic             up_down_i,
  input  logic [WIDTH-1:0] parallel_load_data_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // next count: load wins, otherwise step down (up_down=1) or up
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = parallel_load_data_i;
    end else if (up_down_i) begin
      count_d = count_q - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // count register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sequencer that steers the loadable counter through lo->hi->lo triangle periods,
// then parks it at lo. Outputs are decoded from the state register and the live count.
module counter_sweep_ctrl
  import counter_sweep_pkg::*;
#(
  parameter int unsigned WIDTH = SWEEP_WIDTH
) (
  input  logic                clk_i,
  input  logic                reset_i,
  counter_sweep_ctrl_if.slave sweep_io
);

  localparam logic [PERIOD_WIDTH-1:0] PCNT_ZERO = {PERIOD_WIDTH{1'b0}};
  localparam logic [PERIOD_WIDTH-1:0] PCNT_ONE  = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};

  sweep_state_t            state_q, state_d, fsm_next_s;
  logic [WIDTH-1:0]        lo_q, lo_d;
  logic [WIDTH-1:0]        hi_q, hi_d;
  logic [PERIOD_WIDTH-1:0] periods_q, periods_d;
  logic [PERIOD_WIDTH-1:0] period_cnt_q, period_cnt_d;
  logic                    cfg_err_q, cfg_err_d;

  logic                    start_req_s;
  logic                    cfg_ok_s;
  logic                    at_hi_s;
  logic                    at_lo_s;
  logic                    abort_hit_s;
  logic                    last_period_s;
  logic [PERIOD_WIDTH-1:0] period_cnt_inc_s;
  logic                    ctr_load_s;
  logic                    ctr_up_down_s;
  logic                    busy_s;
  logic                    done_s;

  assign start_req_s      = sweep_io.start && !sweep_io.abort;
  assign cfg_ok_s         = (sweep_io.lo < sweep_io.hi) && (sweep_io.periods != PCNT_ZERO);
  assign at_hi_s          = (sweep_io.ctr_count == hi_q);
  assign at_lo_s          = (sweep_io.ctr_count == lo_q);
  assign abort_hit_s      = sweep_io.abort && (state_q != IDLE);
  assign period_cnt_inc_s = period_cnt_q + PCNT_ONE;
  assign last_period_s    = (period_cnt_inc_s == periods_q);

  // next-state, latched configuration and Mealy counter controls
  always_comb begin
    fsm_next_s    = state_q;
    lo_d          = lo_q;
    hi_d          = hi_q;
    periods_d     = periods_q;
    period_cnt_d  = period_cnt_q;
    cfg_err_d     = 1'b0;
    ctr_load_s    = 1'b0;
    ctr_up_down_s = 1'b0;
    busy_s        = 1'b0;
    done_s        = 1'b0;

    case (state_q)
      IDLE: begin
        ctr_load_s = 1'b1;
        if (start_req_s && cfg_ok_s) begin
          lo_d         = sweep_io.lo;
          hi_d         = sweep_io.hi;
          periods_d    = sweep_io.periods;
          period_cnt_d = PCNT_ZERO;
          fsm_next_s   = LOAD;
        end else if (start_req_s) begin
          cfg_err_d = 1'b1;
        end else begin
          fsm_next_s = IDLE;
        end
      end
      LOAD: begin
        ctr_load_s = 1'b1;
        busy_s     = 1'b1;
        fsm_next_s = UP;
      end
      UP: begin
        busy_s = 1'b1;
        if (at_hi_s) begin
          ctr_up_down_s = 1'b1;
          fsm_next_s    = DOWN;
        end else begin
          ctr_up_down_s = 1'b0;
        end
      end
      DOWN: begin
        busy_s = 1'b1;
        if (!at_lo_s) begin
          ctr_up_down_s = 1'b1;
        end else begin
          // abort freezes the period count even on the trough cycle
          if (!sweep_io.abort) begin
            period_cnt_d = period_cnt_inc_s;
          end else begin
            period_cnt_d = period_cnt_q;
          end
          if (last_period_s) begin
            ctr_load_s = 1'b1;
            fsm_next_s = DONE;
          end else begin
            ctr_up_down_s = 1'b0;
            fsm_next_s    = UP;
          end
        end
      end
      DONE: begin
        ctr_load_s = 1'b1;
        done_s     = 1'b1;
        fsm_next_s = IDLE;
      end
      default: begin
        ctr_load_s = 1'b1;
        fsm_next_s = IDLE;
      end
    endcase

    if (abort_hit_s) begin
      state_d = IDLE;
    end else begin
      state_d = fsm_next_s;
    end
  end

  // state and configuration registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      lo_q         <= {WIDTH{1'b0}};
      hi_q         <= {WIDTH{1'b0}};
      periods_q    <= PCNT_ZERO;
      period_cnt_q <= PCNT_ZERO;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      periods_q    <= periods_d;
      period_cnt_q <= period_cnt_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign sweep_io.ctr_load      = ctr_load_s;
  assign sweep_io.ctr_up_down   = ctr_up_down_s;
  assign sweep_io.ctr_load_data = lo_q;
  assign sweep_io.busy          = busy_s;
  assign sweep_io.done          = done_s;
  assign sweep_io.cfg_err       = cfg_err_q;
  assign sweep_io.period_cnt    = period_cnt_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench: sequencer + counter; expected trajectory computed from triangle arithmetic.
module tb_counter_sweep_ctrl;
  import counter_sweep_pkg::*;

  localparam int W = SWEEP_WIDTH;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;
  int   park_lo     = 0;

  counter_sweep_ctrl_if #(.WIDTH(W)) sw_if ();

  counter #(.WIDTH(W)) u_ctr (
    .clk_i                (clk),
    .reset_i              (reset),
    .load_i               (sw_if.ctr_load),
    .up_down_i            (sw_if.ctr_up_down),
    .parallel_load_data_i (sw_if.ctr_load_data),
    .count_o              (sw_if.ctr_count)
  );

  counter_sweep_ctrl #(.WIDTH(W)) u_dut (
    .clk_i    (clk),
    .reset_i  (reset),
    .sweep_io (sw_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Controller parked: counter held at parked lo, no activity flags.
  task automatic check_parked(input string tag, input int cnt, input int pc, input int cerr);
    check({tag, " count"}, 32'(sw_if.ctr_count), cnt);
    check({tag, " busy"}, 32'(sw_if.busy), 0);
    check({tag, " done"}, 32'(sw_if.done), 0);
    check({tag, " cfg_err"}, 32'(sw_if.cfg_err), cerr);
    check({tag, " load"}, 32'(sw_if.ctr_load), 1);
    check({tag, " load_data"}, 32'(sw_if.ctr_load_data), park_lo);
    check({tag, " period_cnt"}, 32'(sw_if.period_cnt), pc);
  endtask

  // One full sweep: start sampled at edge 0, done expected in cycle 3+2*p*(hi-lo).
  task automatic run_sweep(input int lo, input int hi, input int p);
    int d, last, t, pos, ecnt;
    string tg;
    d    = hi - lo;
    last = 3 + 2 * p * d;
    sw_if.lo      = 8'(lo);
    sw_if.hi      = 8'(hi);
    sw_if.periods = 8'(p);
    sw_if.start   = 1'b1;
    for (int c = 1; c <= last + 1; c++) begin
      tick();
      tg = $sformatf("sweep(%0d,%0d,%0d) c%0d", lo, hi, p, c);
      if (c == 1) begin
        check({tg, " count"}, 32'(sw_if.ctr_count), park_lo);
        check({tg, " busy"}, 32'(sw_if.busy), 1);
        check({tg, " load"}, 32'(sw_if.ctr_load), 1);
        check({tg, " load_data"}, 32'(sw_if.ctr_load_data), lo);
        check({tg, " period_cnt"}, 32'(sw_if.period_cnt), 0);
        sw_if.start   = 1'b0;
        sw_if.lo      = 8'($urandom);
        sw_if.hi      = 8'($urandom);
        sw_if.periods = 8'($urandom);
      end else if (c < last) begin
        t    = c - 2;
        pos  = t % (2 * d);
        ecnt = (pos <= d) ? lo + pos : lo + 2 * d - pos;
        check({tg, " count"}, 32'(sw_if.ctr_count), ecnt);
        check({tg, " busy"}, 32'(sw_if.busy), 1);
        check({tg, " done"}, 32'(sw_if.done), 0);
        check({tg, " up_down"}, 32'(sw_if.ctr_up_down), (pos >= d) ? 1 : 0);
        check({tg, " load"}, 32'(sw_if.ctr_load), (t == 2 * p * d) ? 1 : 0);
        check({tg, " period_cnt"}, 32'(sw_if.period_cnt), (t == 0) ? 0 : (t - 1) / (2 * d));
      end else if (c == last) begin
        check({tg, " count"}, 32'(sw_if.ctr_count), lo);
        check({tg, " busy"}, 32'(sw_if.busy), 0);
        check({tg, " done"}, 32'(sw_if.done), 1);
        check({tg, " load"}, 32'(sw_if.ctr_load), 1);
        check({tg, " period_cnt"}, 32'(sw_if.period_cnt), p);
      end else begin
        park_lo = lo;
        check_parked(tg, lo, p, 0);
      end
    end
  endtask

  // A start that must be refused: cfg_err pulse, nothing else moves.
  task automatic reject_start(input int lo, input int hi, input int p, input int pc);
    string tg;
    tg = $sformatf("reject(%0d,%0d,%0d)", lo, hi, p);
    sw_if.lo      = 8'(lo);
    sw_if.hi      = 8'(hi);
    sw_if.periods = 8'(p);
    sw_if.start   = 1'b1;
    tick();
    check_parked({tg, " c1"}, park_lo, pc, 1);
    sw_if.start = 1'b0;
    tick();
    check_parked({tg, " c2"}, park_lo, pc, 0);
  endtask

  initial begin
    int d, lo, p;
    reset         = 1'b1;
    sw_if.start   = 1'b0;
    sw_if.abort   = 1'b0;
    sw_if.lo      = 8'd0;
    sw_if.hi      = 8'd0;
    sw_if.periods = 8'd0;
    repeat (20) tick();
    check_parked("reset", 0, 0, 0);
    check("reset up_down", 32'(sw_if.ctr_up_down), 0);
    reset = 1'b0;
    tick();

    run_sweep(2, 4, 1);
    run_sweep(2, 4, 2);
    reject_start(5, 5, 1, 2);
    reject_start(1, 9, 0, 2);
    reject_start(200, 100, 3, 2);
    run_sweep(0, 255, 1);
    run_sweep(254, 255, 2);

    // abort wins over start in IDLE
    sw_if.lo = 8'd3; sw_if.hi = 8'd9; sw_if.periods = 8'd1;
    sw_if.start = 1'b1; sw_if.abort = 1'b1;
    tick();
    check_parked("abort+start c1", park_lo, 2, 0);
    sw_if.start = 1'b0; sw_if.abort = 1'b0;
    tick();
    check_parked("abort+start c2", park_lo, 2, 0);

    // abort in UP while count is 3
    sw_if.lo = 8'd1; sw_if.hi = 8'd5; sw_if.periods = 8'd1; sw_if.start = 1'b1;
    tick();
    sw_if.start = 1'b0;
    repeat (3) tick();
    check("abortUP count", 32'(sw_if.ctr_count), 3);
    check("abortUP busy", 32'(sw_if.busy), 1);
    sw_if.abort = 1'b1;
    tick();
    sw_if.abort = 1'b0;
    park_lo = 1;
    check_parked("abortUP c5", 4, 0, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check_parked($sformatf("abortUP hold%0d", i), 1, 0, 0);
    end

    for (int k = 0; k < 8; k++) begin
      d  = int'($urandom_range(1, 6));
      lo = int'($urandom_range(0, 255 - d));
      p  = int'($urandom_range(1, 3));
      run_sweep(lo, lo + d, p);
    end

    // reset in DOWN together with a valid start
    sw_if.lo = 8'd10; sw_if.hi = 8'd13; sw_if.periods = 8'd2; sw_if.start = 1'b1;
    tick();
    sw_if.start = 1'b0;
    repeat (5) tick();
    check("rstDOWN count", 32'(sw_if.ctr_count), 12);
    check("rstDOWN up_down", 32'(sw_if.ctr_up_down), 1);
    check("rstDOWN busy", 32'(sw_if.busy), 1);
    reset = 1'b1;
    sw_if.start = 1'b1; sw_if.lo = 8'd20; sw_if.hi = 8'd30; sw_if.periods = 8'd1;
    tick();
    park_lo = 0;
    check_parked("rstDOWN after", 0, 0, 0);
    check("rstDOWN after up_down", 32'(sw_if.ctr_up_down), 0);
    reset = 1'b0;
    sw_if.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_parked($sformatf("rstDOWN idle%0d", i), 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/counter_sweep_ctrl.md
# counter_sweep_ctrl

Sequencer for the 8-bit up/down loadable counter: drives its `load`, `up_down` and `parallel_load_data` inputs and monitors its `count` output so the counter performs a programmed triangle sweep. The sweep runs `lo → hi → lo` for a configured number of periods, then the counter is parked at `lo`. The block sits beside the counter at top level and exposes a start/busy/done handshake to the rest of the design.

## Interface
- `WIDTH`, 8: counter data width.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: request a sweep. Sampled only in IDLE.
- `abort`  in  1: terminate the sweep at once. Wins over `start`.
- `lo`  in  WIDTH: sweep lower bound. Latched on accepted `start`.
- `hi`  in  WIDTH: sweep upper bound. Latched on accepted `start`.
- `periods`  in  8: number of full triangle periods. Latched on accepted `start`.
- `ctr_count`  in  WIDTH: counter `count` output.
- `ctr_load`  out  1: drives counter `load`.
- `ctr_up_down`  out  1: drives counter `up_down` (0 = increment, 1 = decrement).
- `ctr_load_data`  out  WIDTH: drives counter `parallel_load_data`. Always equals `lo_r`.
- `busy`  out  1: high in LOAD, UP and DOWN.
- `done`  out  1: one-cycle pulse on sweep completion.
- `cfg_err`  out  1: one-cycle pulse when `start` is rejected.
- `period_cnt`  out  8: number of completed periods in the current or last sweep.

## Operation
- The counter runs on every clock and cannot be paused. The controller holds it by asserting `ctr_load` with `lo_r`.
- State register values: IDLE, LOAD, UP, DOWN, DONE.
- Outputs are Mealy: decoded from the state register and `ctr_count`. There is no extra register stage.
- IDLE:
  - Drives `ctr_load`=1.
  - On `start`=1 with `abort`=0, `lo < hi` and `periods != 0`: latch `lo_r`, `hi_r` and `periods_r`; clear `period_cnt`; go to LOAD.
  - On `start` with an invalid configuration: pulse `cfg_err` next cycle, stay in IDLE, leave the latched registers unchanged.
- LOAD: `ctr_load`=1 and `busy`=1. Go to UP. The counter holds `lo_r` from the next cycle.
- UP: `ctr_load`=0.
  - If `ctr_count == hi_r`: `ctr_up_down`=1, go to DOWN.
  - Else: `ctr_up_down`=0.
- DOWN: `ctr_load`=0.
  - If `ctr_count != lo_r`: `ctr_up_down`=1.
  - If `ctr_count == lo_r`: increment `period_cnt`.
    - If the new value equals `periods_r`: `ctr_load`=1 (counter parks at `lo_r`), go to DONE.
    - Otherwise: `ctr_up_down`=0, go to UP.
- DONE: `ctr_load`=1 and `done`=1 for exactly one cycle. Go to IDLE.
- `abort` in LOAD, UP, DOWN or DONE: next state is IDLE, no `done` pulse, `period_cnt` frozen. IDLE then holds the counter at `lo_r` via `ctr_load`.
- Bound comparisons are unsigned and exact. No wrap-around can occur because `lo < hi` is enforced. `hi = 255` and `lo = 0` are legal.
- `period_cnt` saturates by construction, since it never exceeds `periods_r`.

## Timing
- Reset values:
  - State IDLE.
  - `lo_r`, `hi_r`, `periods_r` and `period_cnt` = 0.
  - `busy`=0, `done`=0, `cfg_err`=0.
  - `ctr_load`=1, `ctr_up_down`=0, `ctr_load_data`=0.
- Reset mid-sweep takes effect at the next edge and overrides `abort` and `start`.
- `start` sampled at edge 0 gives LOAD in cycle 1 and `ctr_count == lo` in cycle 2.
- Peak: `ctr_count` reaches exactly `hi_r`, then `hi_r-1`. Trough: reaches exactly `lo_r`. No overshoot.
- `done` is high in cycle 3 + 2·`periods`·(`hi`−`lo`) after the edge that sampled `start`.
- `busy` falls in the same cycle that `done` rises.
- A new `start` is accepted no earlier than the cycle after DONE, i.e. in IDLE.

## Structure
- Package `counter_sweep_pkg`: state enum `sweep_state_t` (IDLE, LOAD, UP, DOWN, DONE) and constant `SWEEP_WIDTH` = 8.
- Single module with no sub-modules. The bounds comparators and the period counter are inline.
- The bench instantiates `counter` and `counter_sweep_ctrl` together.

## Test plan
- Reset 200 ns, then `start` with `lo`=2, `hi`=4, `periods`=1 → `ctr_count` sequence 2,3,4,3,2. `done` in cycle 7. Counter then holds 2.
- `lo`=2, `hi`=4, `periods`=2 → sequence 2,3,4,3,2,3,4,3,2. `done` in cycle 11. `period_cnt` = 2.
- `start` with `lo`=5, `hi`=5, and separately with `periods`=0 → `cfg_err` one-cycle pulse, `busy` stays 0, counter unchanged.
- `lo`=0, `hi`=255, `periods`=1 → peak 255 then 254. No wrap to 0 after 255. `done` after 3+510 cycles.
- `abort` asserted while `ctr_count`=3 in UP → next cycle IDLE, no `done`. Counter loads `lo_r` and holds.
- `reset` asserted mid-DOWN together with `start` → all outputs at reset values after the edge. Sweep not restarted.
